// File: rtl/f32h16_pack_pkg.sv
// f32h16_pack_pkg: shared constants, state type and rounding helper for the float32-to-half packer
package f32h16_pack_pkg;

    localparam logic [14:0] H16_QNAN          = 15'h7E00;
    localparam logic [14:0] H16_INF           = 15'h7C00;
    localparam logic [7:0]  F32_H16_BIAS_DIFF = 8'd112;
    localparam logic [7:0]  SUB_E_MIN         = 8'd102;

    localparam int FF_OVF = 2;
    localparam int FF_UNF = 1;
    localparam int FF_NX  = 0;

    typedef enum logic {S_IDLE, S_LOW} pack_state_t;

    // Round-to-nearest-even increment from lsb, guard and sticky bits
    function automatic logic rne_up(logic lsb, logic g, logic st);
        return g & (st | lsb);
    endfunction

endpackage

// File: rtl/f32h16_pack_f32_to_f16.sv
// f32_to_f16: combinational IEEE-754 float32 to binary16 converter with round-to-nearest-even
//   i_f32   : float32 operand
//   o_half  : binary16 result
//   o_flags : {overflow, underflow, inexact} for this conversion
module f32_to_f16
    import f32h16_pack_pkg::*;
(
    input  logic [31:0] i_f32,
    output logic [15:0] o_half,
    output logic [2:0]  o_flags
);

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_m;
    logic        w_e_max;
    logic        w_zero;
    logic        w_big;
    logic        w_norm;
    logic        w_sub;
    logic [4:0]  w_nexp;
    logic [14:0] w_nsum;
    logic        w_nnx;
    logic [7:0]  w_sh;
    logic [33:0] w_sext;
    logic [10:0] w_ssum;
    logic        w_snx;
    logic [14:0] w_body;
    logic        w_ovf;
    logic        w_nx;

    assign w_s     = i_f32[31];
    assign w_e     = i_f32[30:23];
    assign w_m     = i_f32[22:0];
    assign w_e_max = w_e == 8'd255;
    assign w_zero  = w_e == 8'd0 && w_m == 23'd0;
    assign w_big   = !w_e_max && w_e > 8'd142;
    assign w_norm  = w_e >= 8'd113 && w_e <= 8'd142;
    assign w_sub   = w_e >= SUB_E_MIN && w_e <= F32_H16_BIAS_DIFF;

    // Normal range: rebias and round; a carry out of the mantissa bumps the exponent,
    // which for exponent 30 lands exactly on the infinity encoding.
    assign w_nexp = w_e[4:0] - F32_H16_BIAS_DIFF[4:0];
    assign w_nsum = {w_nexp, w_m[22:13]} + {14'd0, rne_up(w_m[13], w_m[12], |w_m[11:0])};
    assign w_nnx  = w_m[12] | (|w_m[11:0]);

    // Subnormal range: the significand is pre-shifted by 14 via the fixed field positions,
    // so only the remaining 0..10 bit shift is variable and nothing drops off the low end.
    assign w_sh   = F32_H16_BIAS_DIFF - w_e;
    assign w_sext = {1'b1, w_m, 10'd0} >> w_sh;
    assign w_ssum = {1'b0, w_sext[33:24]} + {10'd0, rne_up(w_sext[24], w_sext[23], |w_sext[22:0])};
    assign w_snx  = w_sext[23] | (|w_sext[22:0]);

    assign w_body = w_e_max ? (w_m != 23'd0 ? H16_QNAN : H16_INF) :
                    w_zero  ? 15'd0 :
                    w_big   ? H16_INF :
                    w_norm  ? w_nsum :
                    w_sub   ? {4'd0, w_ssum} : 15'd0;

    assign w_ovf = w_big | (w_norm & (&w_nsum[14:10]));
    assign w_nx  = w_e_max ? 1'b0 :
                   w_zero  ? 1'b0 :
                   w_big   ? 1'b1 :
                   w_norm  ? w_nnx :
                   w_sub   ? w_snx : 1'b1;

    assign o_half           = {w_s, w_body};
    assign o_flags[FF_OVF]  = w_ovf;
    assign o_flags[FF_UNF]  = w_nx & (w_body[14:10] == 5'd0);
    assign o_flags[FF_NX]   = w_nx;

endmodule

// File: rtl/f32h16_pack.sv
// f32h16_pack: streams float32 words, converts each to binary16 and packs pairs into 32-bit words
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last     : float32 input stream
//   out_valid/out_ready/out_data/out_last : packed {half_hi, half_lo} output stream
//   clr_flags, fflags               : sticky {overflow, underflow, inexact} and its clear
module f32h16_pack
    import f32h16_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        clr_flags,
    output logic [2:0]  fflags
);

    logic [15:0] w_half;
    logic [2:0]  w_flags;
    logic        w_acc;
    logic        w_emit;

    pack_state_t r_state;
    logic [15:0] r_lo;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_last;
    logic [2:0]  r_fflags;

    f32_to_f16 u_cvt (
        .i_f32   (in_data),
        .o_half  (w_half),
        .o_flags (w_flags)
    );

    assign in_ready  = !r_out_valid | out_ready;
    assign w_acc     = in_valid & in_ready;
    // Every accept emits except a non-last element that opens a pair
    assign w_emit    = w_acc & (in_last | (r_state == S_LOW));

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign fflags    = r_fflags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lo        <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_last  <= 1'b0;
            r_fflags    <= 3'd0;
        end else begin
            if (w_acc)
                r_state <= w_emit ? S_IDLE : S_LOW;
            if (w_acc & !w_emit)
                r_lo <= w_half;
            if (w_emit) begin
                r_out_data <= (r_state == S_LOW) ? {w_half, r_lo} : {16'h0000, w_half};
                r_out_last <= in_last;
            end
            r_out_valid <= w_emit | (r_out_valid & !out_ready);
            // A new flag from this accept survives a simultaneous clear
            r_fflags    <= (clr_flags ? 3'd0 : r_fflags) | (w_acc ? w_flags : 3'd0);
        end
    end

endmodule

// File: tb/tb_f32h16_pack.sv
// tb_f32h16_pack: directed and randomized checks of f32h16_pack against a real-arithmetic model
module tb_f32h16_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        clr_flags = 1'b0;
    logic [2:0]  fflags;

    int          n_chk = 0;
    int          n_err = 0;
    logic [32:0] q[$];
    logic        m_low = 1'b0;
    logic [15:0] m_lo = 16'd0;
    logic [2:0]  m_ff = 3'd0;

    f32h16_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .clr_flags (clr_flags),
        .fflags    (fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int rne(real v);
        real fl;
        int  r;
        fl = $floor(v);
        r  = $rtoi(fl);
        if (v - fl > 0.5 || (v - fl == 0.5 && r % 2 == 1))
            r++;
        return r;
    endfunction

    // Returns {ovf, unf, nx, half}; works on the real value, not the bit fields
    function automatic logic [18:0] ref_conv(logic [31:0] x);
        int          e, mm, r, ex;
        real         a, v;
        logic [14:0] b;
        logic        nx;
        e  = int'(x[30:23]);
        mm = int'(x[22:0]);
        if (e == 255)
            return {3'b000, x[31], (mm != 0 ? 15'h7E00 : 15'h7C00)};
        a = (e == 0) ? mm * 2.0 ** (-149) : (8388608.0 + mm) * 2.0 ** (e - 150);
        if (a == 0.0)
            return {3'b000, x[31], 15'h0000};
        if (a >= 65520.0)
            return {3'b101, x[31], 15'h7C00};
        if (a < 2.0 ** (-14)) begin
            v  = a * 16777216.0;
            r  = rne(v);
            nx = v != real'(r);
            b  = 15'(r);
        end else begin
            ex = -14;
            while (a >= 2.0 ** (ex + 1))
                ex++;
            v  = a * 2.0 ** (10 - ex);
            r  = rne(v);
            nx = v != real'(r);
            if (r == 2048) begin
                ex++;
                r = 1024;
            end
            b = 15'((ex + 15) * 1024 + r - 1024);
        end
        return {1'b0, nx && b[14:10] == 5'd0, nx, x[31], b};
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [7:0]  e;
        logic [22:0] m;
        int          k;
        k = int'($urandom_range(0, 7));
        m = 23'($urandom);
        e = k == 0 ? 8'($urandom_range(0, 1) * 255) :
            k < 3  ? 8'($urandom_range(98, 114)) :
            k < 5  ? 8'($urandom_range(138, 146)) : 8'($urandom_range(1, 254));
        if ($urandom_range(0, 2) == 0)
            m[11:0] = 12'h000;
        if ($urandom_range(0, 7) == 0)
            m = 23'd0;
        return {1'($urandom), e, m};
    endfunction

    // One clock: check outputs against the model, then advance the model by this cycle's handshakes
    task automatic tick();
        logic [18:0] c;
        logic        acc;
        @(negedge clk);
        chk("fflags", 64'(fflags), 64'(m_ff));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() == 0 || out_ready));
        if (out_valid && out_ready && q.size() != 0)
            chk("out_word", 64'({out_last, out_data}), 64'(q.pop_front()));
        acc  = in_valid & in_ready;
        c    = ref_conv(in_data);
        m_ff = (clr_flags ? 3'd0 : m_ff) | (acc ? c[18:16] : 3'd0);
        if (acc) begin
            if (!m_low && !in_last) begin
                m_lo  = c[15:0];
                m_low = 1'b1;
            end else begin
                q.push_back(m_low ? {in_last, c[15:0], m_lo} : {in_last, 16'h0000, c[15:0]});
                m_low = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b0;
        q.delete();
        m_low = 1'b0;
        m_ff  = 3'd0;
        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst fflags", 64'(fflags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic dconv(string tag, logic [31:0] d, logic [15:0] h, logic [2:0] f);
        clr_flags = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        clr_flags = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk({tag, " word"}, 64'({out_valid, out_last, out_data}), 64'({2'b11, 16'h0000, h}));
        chk({tag, " flags"}, 64'(fflags), 64'(f));
        tick();
    endtask

    initial begin
        do_reset();

        // Pair packing
        out_ready = 1'b1;
        clr_flags = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        in_last   = 1'b0;
        tick();
        chk("pair first no emit", 64'(out_valid), 64'd0);
        in_data = 32'h40000000;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pair word", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'h40003C00}));
        chk("pair flags", 64'(fflags), 64'd0);
        tick();

        dconv("odd", 32'h3FC00000, 16'h3E00, 3'b000);
        dconv("max normal", 32'h477FE000, 16'h7BFF, 3'b000);
        dconv("round ovf", 32'h477FF000, 16'h7C00, 3'b101);
        dconv("tie even", 32'h3F801000, 16'h3C00, 3'b001);
        dconv("tie up", 32'h3F803000, 16'h3C02, 3'b001);
        dconv("min sub", 32'h33800000, 16'h0001, 3'b000);
        dconv("half min sub", 32'h33000000, 16'h0000, 3'b011);
        dconv("above half min", 32'h33000001, 16'h0001, 3'b011);
        dconv("sub to normal", 32'h387FF000, 16'h0400, 3'b001);
        dconv("big exp", 32'h7F000000, 16'h7C00, 3'b101);
        dconv("qnan", 32'hFFC00001, 16'hFE00, 3'b000);
        dconv("neg inf", 32'hFF800000, 16'hFC00, 3'b000);
        dconv("neg zero", 32'h80000000, 16'h8000, 3'b000);
        dconv("f32 denorm", 32'h00000001, 16'h0000, 3'b011);

        // Set wins over clear: underflow flags are set from the previous step
        clr_flags = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h477FF000;
        in_last   = 1'b1;
        tick();
        clr_flags = 1'b0;
        in_valid  = 1'b0;
        chk("clr vs set", 64'(fflags), 64'd5);
        tick();

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h40400000;
        in_last   = 1'b0;
        tick();
        in_data = 32'h40800000;
        in_last = 1'b1;
        tick();
        in_data = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp hold", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'h44004200}));
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp next word", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'h00003C00}));
        tick();

        // Reset mid-pair
        in_valid = 1'b1;
        in_data  = 32'h40400000;
        in_last  = 1'b0;
        tick();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        in_last   = 1'b0;
        tick();
        in_data = 32'h40000000;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post rst word", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'h40003C00}));
        tick();
        tick();
        chk("post rst idle", 64'(out_valid), 64'd0);

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = rand_f32();
            in_last   = $urandom_range(0, 3) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            clr_flags = $urandom_range(0, 15) == 0;
            tick();
        end
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        chk("drain", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
